// File: rtl/ara_inval_coalescer.sv
// rtl/ara_inval_coalescer.sv - in-order line-invalidation FIFO that coalesces repeated lines (optional stats: INVAL_COALESCE_STATS_EN)
module ara_inval_coalescer #(
    parameter int Depth       = 4,
    parameter int AddrWidth   = 64,
    parameter int L1LineWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] inval_addr_i,
    input  logic                 inval_valid_i,
    output logic                 inval_ready_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic                 empty_o
`ifdef INVAL_COALESCE_STATS_EN
    ,
    output logic [31:0]          coalesced_cnt_o
`endif
);

    localparam int OffW = $clog2(L1LineWidth);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-OffW){1'b1}}, {OffW{1'b0}}};
    localparam logic [CntW-1:0]      CntFull  = CntW'(Depth);

    logic [AddrWidth-1:0] r_addr [Depth];
    logic [Depth-1:0]     r_valid;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [PtrW-1:0]      r_wr_ptr;
    logic [CntW-1:0]      r_count;

    logic [AddrWidth-1:0] w_line;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_up_xfer;
    logic                 w_push;
    logic                 w_coalesce;

    assign w_line  = inval_addr_i & LineMask;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CntFull);
    assign w_pop   = inval_valid_o && inval_ready_i;

    // Match the incoming line against every queued entry; the head leaving this cycle cannot absorb it
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (r_valid[i] && (r_addr[i] == w_line) && !(w_pop && (PtrW'(i) == r_rd_ptr))) begin
                w_hit = 1'b1;
            end
        end
    end

    // Full is taken from registered state only, so a same-cycle pop never makes room
    assign inval_ready_o = !en_i || w_hit || !w_full;
    assign w_up_xfer     = inval_valid_i && inval_ready_o;
    assign w_push        = w_up_xfer && en_i && !w_hit;
    assign w_coalesce    = w_up_xfer && en_i && w_hit;

    assign inval_valid_o = !w_empty;
    assign inval_addr_o  = r_addr[r_rd_ptr];
    assign empty_o       = w_empty;

    // Entry storage, valid bits and pointers; pop clears the head before push fills the tail
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_addr[i] <= '0;
            end
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_addr[r_wr_ptr]  <= w_line;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INVAL_COALESCE_STATS_EN
    logic [31:0] r_coalesced_cnt;

    // Saturating count of upstream transfers absorbed by an existing entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_coalesced_cnt <= '0;
        end else if (w_coalesce && (r_coalesced_cnt != 32'hFFFF_FFFF)) begin
            r_coalesced_cnt <= r_coalesced_cnt + 32'd1;
        end
    end

    assign coalesced_cnt_o = r_coalesced_cnt;
`else
    logic w_unused_coalesce;
    assign w_unused_coalesce = w_coalesce;
`endif

endmodule

// File: tb/tb_ara_inval_coalescer.sv
// tb/tb_ara_inval_coalescer.sv - directed-vector bench for ara_inval_coalescer
`timescale 1ns/1ps
module tb_ara_inval_coalescer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [63:0] inval_addr_i;
    logic        inval_valid_i;
    logic        inval_ready_o;
    logic [63:0] inval_addr_o;
    logic        inval_valid_o;
    logic        inval_ready_i;
    logic        empty_o;
`ifdef INVAL_COALESCE_STATS_EN
    logic [31:0] coalesced_cnt_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    ara_inval_coalescer #(.Depth(4), .AddrWidth(64), .L1LineWidth(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .inval_addr_i  (inval_addr_i),
        .inval_valid_i (inval_valid_i),
        .inval_ready_o (inval_ready_o),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .empty_o       (empty_o)
`ifdef INVAL_COALESCE_STATS_EN
        ,
        .coalesced_cnt_o (coalesced_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one upstream beat, check it is accepted, clock it in, then idle the input
    task automatic push(input logic [63:0] a, input string tag);
        inval_addr_i  = a;
        inval_valid_i = 1'b1;
        #1;
        chk(tag, {63'd0, inval_ready_o}, 64'd1);
        tick();
        inval_valid_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        en_i          = 1'b1;
        inval_addr_i  = '0;
        inval_valid_i = 1'b0;
        inval_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", {63'd0, inval_valid_o}, 64'd0);
        chk("rst_empty", {63'd0, empty_o}, 64'd1);
        chk("rst_addr", inval_addr_o, 64'd0);
        rst_i = 1'b0;
        tick();

        // Single push, line aligned, visible next cycle
        push(64'h1004, "p1_ready");
        chk("p1_valid", {63'd0, inval_valid_o}, 64'd1);
        chk("p1_addr", inval_addr_o, 64'h1000);
        chk("p1_empty", {63'd0, empty_o}, 64'd0);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        chk("p1_drained", {63'd0, empty_o}, 64'd1);

        // Coalesce a second address on the same line
        push(64'h2000, "c_push0");
        push(64'h2008, "c_push1_hit");
        chk("c_head", inval_addr_o, 64'h2000);
`ifdef INVAL_COALESCE_STATS_EN
        chk("c_stat", {32'd0, coalesced_cnt_o}, 64'd1);
`endif
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        chk("c_one_entry", {63'd0, empty_o}, 64'd1);

        // Fill to Depth, full backpressure, hit still accepted, full not freed by pop
        push(64'h00, "f_push0");
        push(64'h10, "f_push1");
        push(64'h20, "f_push2");
        push(64'h30, "f_push3");
        inval_addr_i  = 64'h40;
        inval_valid_i = 1'b1;
        #1;
        chk("f_full_ready", {63'd0, inval_ready_o}, 64'd0);
        inval_addr_i = 64'h18;
        #1;
        chk("f_hit_ready", {63'd0, inval_ready_o}, 64'd1);
        tick();
        inval_addr_i  = 64'h40;
        inval_ready_i = 1'b1;
        #1;
        chk("f_pop_no_free", {63'd0, inval_ready_o}, 64'd0);
        inval_valid_i = 1'b0;
        chk("f_out0", inval_addr_o, 64'h00);
        tick();
        chk("f_out1", inval_addr_o, 64'h10);
        tick();
        chk("f_out2", inval_addr_o, 64'h20);
        tick();
        chk("f_out3", inval_addr_o, 64'h30);
        tick();
        chk("f_drained", {63'd0, empty_o}, 64'd1);
        inval_ready_i = 1'b0;

        // Head popping while the same line arrives: re-issued, not coalesced
        push(64'h100, "r_push0");
        inval_ready_i = 1'b1;
        inval_addr_i  = 64'h104;
        inval_valid_i = 1'b1;
        #1;
        chk("r_ready", {63'd0, inval_ready_o}, 64'd1);
        chk("r_first", inval_addr_o, 64'h100);
        tick();
        inval_valid_i = 1'b0;
        chk("r_valid2", {63'd0, inval_valid_o}, 64'd1);
        chk("r_second", inval_addr_o, 64'h100);
        tick();
        chk("r_drained", {63'd0, empty_o}, 64'd1);
        inval_ready_i = 1'b0;

        // Coherence disabled: accept and discard, existing entries still drain
        en_i = 1'b0;
        push(64'h500, "d_ready_empty");
        chk("d_empty", {63'd0, empty_o}, 64'd1);
        en_i = 1'b1;
        push(64'h300, "d_push300");
        en_i = 1'b0;
        push(64'h500, "d_ready_q");
        chk("d_head", inval_addr_o, 64'h300);
        inval_ready_i = 1'b1;
        tick();
        inval_ready_i = 1'b0;
        chk("d_drained", {63'd0, empty_o}, 64'd1);
        en_i = 1'b1;

        // Mid-operation reset drops everything at once
        push(64'h600, "x_push0");
        push(64'h610, "x_push1");
        push(64'h620, "x_push2");
        chk("x_pre_valid", {63'd0, inval_valid_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        chk("x_in_valid", {63'd0, inval_valid_o}, 64'd0);
        chk("x_in_empty", {63'd0, empty_o}, 64'd1);
        chk("x_in_addr", inval_addr_o, 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("x_post_valid", {63'd0, inval_valid_o}, 64'd0);
        chk("x_post_empty", {63'd0, empty_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
